// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall controller with divider and data-SRAM wait FSMs; optional PIPE_CTRL_PERF_EN stall counters
module pipe_ctrl #(
  parameter int DIV_TIMEOUT = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stallreq_for_load,
  input  logic       div_start,
  input  logic       div_ready,
  input  logic       mem_req,
  input  logic       mem_data_ok,
`ifdef PIPE_CTRL_PERF_EN
  output logic [31:0] stall_cyc_load,
  output logic [31:0] stall_cyc_div,
  output logic [31:0] stall_cyc_mem,
`endif
  output logic [5:0] stall,
  output logic       div_busy,
  output logic       div_err
);

  typedef enum logic {D_IDLE, D_BUSY} dstate_t;
  typedef enum logic {M_IDLE, M_WAIT} mstate_t;

  localparam logic [5:0] MEM_MASK  = 6'b011111;
  localparam logic [5:0] DIV_MASK  = 6'b001111;
  localparam logic [5:0] LOAD_MASK = 6'b000111;
  localparam logic [5:0] TIMEOUT   = 6'(DIV_TIMEOUT);
  localparam logic [5:0] CNT_MAX   = 6'd63;

  dstate_t    dstate_q, dstate_d;
  mstate_t    mstate_q, mstate_d;
  logic [5:0] div_cnt_q, div_cnt_d;
  logic       div_err_q, div_err_d;
  logic       div_hold, mem_hold, load_hold;

  // Divider FSM: busy from the cycle after an unfinished start until div_ready
  always_comb begin
    dstate_d  = dstate_q;
    div_cnt_d = div_cnt_q;
    div_err_d = div_err_q;
    div_hold  = 1'b0;
    case (dstate_q)
      D_IDLE: begin
        if (div_start && !div_ready) begin
          dstate_d  = D_BUSY;
          div_cnt_d = 6'd0;
          div_hold  = 1'b1;
        end
      end
      D_BUSY: begin
        div_cnt_d = (div_cnt_q == CNT_MAX) ? CNT_MAX : div_cnt_q + 6'd1;
        if (div_cnt_d >= TIMEOUT) div_err_d = 1'b1;
        if (div_ready) dstate_d = D_IDLE;
        else           div_hold = 1'b1;
      end
      default: dstate_d = D_IDLE;
    endcase
  end

  // Memory FSM: waits from the cycle after an unfinished request until mem_data_ok
  always_comb begin
    mstate_d = mstate_q;
    mem_hold = 1'b0;
    case (mstate_q)
      M_IDLE: begin
        if (mem_req && !mem_data_ok) begin
          mstate_d = M_WAIT;
          mem_hold = 1'b1;
        end
      end
      M_WAIT: begin
        if (mem_data_ok) mstate_d = M_IDLE;
        else             mem_hold = 1'b1;
      end
      default: mstate_d = M_IDLE;
    endcase
  end

  // Stall vector is the OR of active masks, forced quiet while reset is held
  always_comb begin
    load_hold = stallreq_for_load;
    stall     = 6'b000000;
    if (rst) begin
      if (mem_hold)  stall = stall | MEM_MASK;
      if (div_hold)  stall = stall | DIV_MASK;
      if (load_hold) stall = stall | LOAD_MASK;
    end
  end

  // State, divide counter and sticky timeout flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dstate_q  <= D_IDLE;
      mstate_q  <= M_IDLE;
      div_cnt_q <= 6'd0;
      div_err_q <= 1'b0;
    end else begin
      dstate_q  <= dstate_d;
      mstate_q  <= mstate_d;
      div_cnt_q <= div_cnt_d;
      div_err_q <= div_err_d;
    end
  end

  assign div_busy = (dstate_q == D_BUSY);
  assign div_err  = div_err_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] cyc_load_q, cyc_load_d;
  logic [31:0] cyc_div_q, cyc_div_d;
  logic [31:0] cyc_mem_q, cyc_mem_d;

  // Per-mask active-cycle counters, wrapping naturally at 2^32
  always_comb begin
    cyc_load_d = cyc_load_q + {31'd0, load_hold};
    cyc_div_d  = cyc_div_q  + {31'd0, div_hold};
    cyc_mem_d  = cyc_mem_q  + {31'd0, mem_hold};
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_load_q <= 32'd0;
      cyc_div_q  <= 32'd0;
      cyc_mem_q  <= 32'd0;
    end else begin
      cyc_load_q <= cyc_load_d;
      cyc_div_q  <= cyc_div_d;
      cyc_mem_q  <= cyc_mem_d;
    end
  end

  assign stall_cyc_load = cyc_load_q;
  assign stall_cyc_div  = cyc_div_q;
  assign stall_cyc_mem  = cyc_mem_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - directed vector bench for pipe_ctrl
module tb_pipe_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       stallreq_for_load, div_start, div_ready, mem_req, mem_data_ok;
  logic [5:0] stall;
  logic       div_busy, div_err;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cyc_load, stall_cyc_div, stall_cyc_mem;
`endif

  int checks = 0;
  int errors = 0;

  pipe_ctrl #(.DIV_TIMEOUT(40)) dut (
    .clk               (clk),
    .rst               (rst),
    .stallreq_for_load (stallreq_for_load),
    .div_start         (div_start),
    .div_ready         (div_ready),
    .mem_req           (mem_req),
    .mem_data_ok       (mem_data_ok),
`ifdef PIPE_CTRL_PERF_EN
    .stall_cyc_load    (stall_cyc_load),
    .stall_cyc_div     (stall_cyc_div),
    .stall_cyc_mem     (stall_cyc_mem),
`endif
    .stall             (stall),
    .div_busy          (div_busy),
    .div_err           (div_err)
  );

  always #5 clk = ~clk;

  // inputs packed as {load, div_start, div_ready, mem_req, mem_data_ok}
  typedef struct {
    logic [4:0] in;
    logic [5:0] exp_stall;
    logic       exp_busy;
  } vec_t;

  vec_t tbl[26];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {stallreq_for_load, div_start, div_ready, mem_req, mem_data_ok} = v;
  endtask

  // Called just after a rising edge: apply inputs, check at the falling edge, move past next rising edge
  task automatic cycle(input logic [4:0] v, input string name,
                       input logic [5:0] es, input logic eb, input logic ee);
    drive(v);
    @(negedge clk);
    check({name, ".stall"}, {26'd0, stall}, {26'd0, es});
    check({name, ".busy"}, {31'd0, div_busy}, {31'd0, eb});
    check({name, ".err"}, {31'd0, div_err}, {31'd0, ee});
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    drive(5'b11111);
    #2;
    check("rst.stall", {26'd0, stall}, 32'd0);
    check("rst.busy", {31'd0, div_busy}, 32'd0);
    check("rst.err", {31'd0, div_err}, 32'd0);
    @(posedge clk);
    #1;
    drive(5'b00000);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{5'b00000, 6'b000000, 1'b0};
    tbl[1]  = '{5'b10000, 6'b000111, 1'b0};
    tbl[2]  = '{5'b00000, 6'b000000, 1'b0};
    tbl[3]  = '{5'b00010, 6'b011111, 1'b0};
    tbl[4]  = '{5'b00000, 6'b011111, 1'b0};
    tbl[5]  = '{5'b00010, 6'b011111, 1'b0};
    tbl[6]  = '{5'b00001, 6'b000000, 1'b0};
    tbl[7]  = '{5'b00000, 6'b000000, 1'b0};
    tbl[8]  = '{5'b00011, 6'b000000, 1'b0};
    tbl[9]  = '{5'b00000, 6'b000000, 1'b0};
    tbl[10] = '{5'b01000, 6'b001111, 1'b0};
    tbl[11] = '{5'b00000, 6'b001111, 1'b1};
    tbl[12] = '{5'b01000, 6'b001111, 1'b1};
    tbl[13] = '{5'b00010, 6'b011111, 1'b1};
    tbl[14] = '{5'b10000, 6'b011111, 1'b1};
    tbl[15] = '{5'b00001, 6'b001111, 1'b1};
    tbl[16] = '{5'b00000, 6'b001111, 1'b1};
    tbl[17] = '{5'b00100, 6'b000000, 1'b1};
    tbl[18] = '{5'b00000, 6'b000000, 1'b0};
    tbl[19] = '{5'b01100, 6'b000000, 1'b0};
    tbl[20] = '{5'b00000, 6'b000000, 1'b0};
    tbl[21] = '{5'b11000, 6'b001111, 1'b0};
    tbl[22] = '{5'b10100, 6'b000111, 1'b1};
    tbl[23] = '{5'b00000, 6'b000000, 1'b0};
    tbl[24] = '{5'b10010, 6'b011111, 1'b0};
    tbl[25] = '{5'b00001, 6'b000000, 1'b0};

    rst = 1'b0;
    drive(5'b00000);
    do_reset();

    for (int i = 0; i < 26; i++)
      cycle(tbl[i].in, $sformatf("vec%0d", i), tbl[i].exp_stall, tbl[i].exp_busy, 1'b0);

    // Long divide: start at cycle 0, ready at cycle 33
    do_reset();
    for (int t = 0; t <= 34; t++)
      cycle((t == 0) ? 5'b01000 : (t == 33) ? 5'b00100 : 5'b00000,
            $sformatf("div33.c%0d", t),
            (t <= 32) ? 6'b001111 : 6'b000000,
            (t >= 1 && t <= 33), 1'b0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf.div", stall_cyc_div, 32'd33);
    check("perf.load", stall_cyc_load, 32'd0);
    check("perf.mem", stall_cyc_mem, 32'd0);
`endif

    // Timeout: no div_ready; flag appears after the 40th busy cycle
    do_reset();
    for (int t = 0; t <= 45; t++)
      cycle((t == 0) ? 5'b01000 : 5'b00000, $sformatf("tmo.c%0d", t),
            6'b001111, (t >= 1), (t >= 41));

    // Asynchronous reset mid-busy, away from any clock edge
    rst = 1'b0;
    drive(5'b11111);
    #1;
    check("arst.stall", {26'd0, stall}, 32'd0);
    check("arst.busy", {31'd0, div_busy}, 32'd0);
    check("arst.err", {31'd0, div_err}, 32'd0);
    @(negedge clk);
    drive(5'b00000);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cycle(5'b01000, "post.c0", 6'b001111, 1'b0, 1'b0);
    cycle(5'b00000, "post.c1", 6'b001111, 1'b1, 1'b0);
    cycle(5'b00100, "post.c2", 6'b000000, 1'b1, 1'b0);
    cycle(5'b00000, "post.c3", 6'b000000, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter DIV_TIMEOUT, default 40, the maximum divider busy cycles before div_err is raised (range 2..63).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port stallreq_for_load, input, 1, ID load-use hazard request.
REQ-005 SHALL have port div_start, input, 1, EX divider start pulse for div/divu.
REQ-006 SHALL have port div_ready, input, 1, divider result-valid pulse.
REQ-007 SHALL have port mem_req, input, 1, MEM data-SRAM access issued this cycle.
REQ-008 SHALL have port mem_data_ok, input, 1, data-SRAM completion.
REQ-009 SHALL have port stall, output, 6 (StallBus), freeze vector: bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 WB; Stop=1.
REQ-010 SHALL have port div_busy, output, 1, divider FSM not IDLE.
REQ-011 SHALL have port div_err, output, 1, sticky divider timeout flag.

Function
REQ-012 SHALL contain two independent FSMs: DFSM {D_IDLE, D_BUSY} and MFSM {M_IDLE, M_WAIT}.
REQ-013 DFSM: D_IDLE->D_BUSY when div_start=1 and div_ready=0; D_BUSY->D_IDLE when div_ready=1; div_start in D_BUSY ignored.
REQ-014 MFSM: M_IDLE->M_WAIT when mem_req=1 and mem_data_ok=0; M_WAIT->M_IDLE when mem_data_ok=1; mem_req in M_WAIT ignored.
REQ-015 Masks (combinational): mem_hold = (mem_req & ~mem_data_ok & M_IDLE) | (M_WAIT & ~mem_data_ok) -> 6'b011111.
REQ-016 div_hold = (div_start & ~div_ready & D_IDLE) | (D_BUSY & ~div_ready) -> 6'b001111.
REQ-017 load_hold = stallreq_for_load -> 6'b000111 (one bubble into EX, no cycle stretch).
REQ-018 stall SHALL be bitwise OR of active masks; zero-latency (same cycle as cause).
REQ-019 Completion cycle (div_ready or mem_data_ok high) SHALL drop that FSM's mask in that same cycle.
REQ-020 Simultaneous mem_hold and div_hold: stall=6'b011111; both FSMs advance independently.
REQ-021 div_cnt (6-bit internal): cleared entering D_BUSY, +1 per D_BUSY cycle, saturates at 63.
REQ-022 div_err SHALL set when div_cnt reaches DIV_TIMEOUT in D_BUSY; stays set until reset; does not alter stall.
REQ-023 div_busy = (DFSM==D_BUSY), registered-state derived.

Reset
REQ-024 rst=0 SHALL asynchronously force D_IDLE, M_IDLE, div_cnt=0, div_err=0, perf counters=0.
REQ-025 During reset stall SHALL equal 6'b000000 regardless of inputs; div_busy=0.
REQ-026 Reset mid-operation SHALL abandon pending divide/memory wait; first post-reset cycle samples inputs afresh.

Configuration
REQ-027 Macro PIPE_CTRL_PERF_EN SHALL, when defined, add outputs stall_cyc_load, stall_cyc_div, stall_cyc_mem (32-bit each) counting cycles each mask is active, wrapping at 2^32.
REQ-028 Without PIPE_CTRL_PERF_EN those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-029 stallreq_for_load=1 one cycle, others 0 -> stall=6'b000111 that cycle, 6'b000000 next.
REQ-030 div_start=1 cycle 0, div_ready=1 cycle 33 -> stall=6'b001111 cycles 0..32, 0 at cycle 33; div_busy=1 cycles 1..33; div_err=0.
REQ-031 mem_req=1 cycle 0, mem_data_ok=1 cycle 3 -> stall=6'b011111 cycles 0..2, 0 at cycle 3; mem_req=1 with mem_data_ok=1 same cycle -> stall=0, no M_WAIT.
REQ-032 D_BUSY and M_WAIT overlapping, plus stallreq_for_load=1 -> stall=6'b011111; after mem_data_ok stall=6'b001111 until div_ready.
REQ-033 div_start, no div_ready for 45 cycles (DIV_TIMEOUT=40) -> div_err=1 after 40th busy cycle; rst=0 pulse mid-busy -> stall=0, div_busy=0, div_err=0 immediately.
REQ-034 With PIPE_CTRL_PERF_EN, REQ-030 stimulus -> stall_cyc_div=33, stall_cyc_load=0, stall_cyc_mem=0.
